error_campaign_sequencer: RTL and testbench

ERROR_CAMPAIGN_SEQUENCER -- requirements
Module: error_campaign_sequencer

---
 rtl/error_campaign_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_error_campaign_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/error_campaign_sequencer.sv
// -----------------------------------------------------------------------------
// error_campaign_sequencer
//
// Drives a stuck-at error injector across a range of codeword bit indices and
// measures, for each index, how many of a fixed number of decoded codewords
// were flagged as erroneous by the decoder.
//
// For every index in [first, last] the sequencer:
//   SETUP  : one cycle that lets the injector register the threshold
//   RUN    : counts decoder strobes until the sample budget is reached
//   REPORT : presents {idx, detect count} until the consumer accepts it
// and after the last index pulses o_done for one cycle.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_clk_en              global enable; all state holds while low
//   i_start, i_abort      campaign start pulse / abort back to IDLE
//   i_threshold           injection probability threshold (latched at start)
//   i_first_idx/last_idx  inclusive sweep range (latched at start)
//   i_num_samples         codewords evaluated per index (latched at start)
//   i_dec_valid/dec_err   decoder result strobe / detected-error flag
//   i_result_ready        consumer accepts the current result
//   o_constant            threshold to the injector (SETUP/RUN only)
//   o_random_idx          stuck-at bit index to the injector
//   o_inj_clk_en          injector LFSR enable (RUN only)
//   o_result_*            per-index result channel
//   o_busy/o_done/o_cfg_err status
//   o_dbg_state           current FSM state, for observation only
//
// Result handshake: o_result_valid stays high with o_result_idx and
// o_result_count held constant until a rising edge where i_result_ready and
// i_clk_en are both high; that edge is the transfer, and the fields may only
// change after it.
// -----------------------------------------------------------------------------
module error_campaign_sequencer #(
   parameter int CODEWORD_LENGTH = 29,
   parameter int CNT_W           = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clk_en,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [31:0]      i_threshold,
   input  logic [4:0]       i_first_idx,
   input  logic [4:0]       i_last_idx,
   input  logic [CNT_W-1:0] i_num_samples,
   input  logic             i_dec_valid,
   input  logic             i_dec_err,
   input  logic             i_result_ready,
   output logic [31:0]      o_constant,
   output logic [4:0]       o_random_idx,
   output logic             o_inj_clk_en,
   output logic             o_result_valid,
   output logic [4:0]       o_result_idx,
   output logic [CNT_W-1:0] o_result_count,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_cfg_err,
   output logic [2:0]       o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_RUN    = 3'd2,
      ST_REPORT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [5:0] CW_LEN = 6'(CODEWORD_LENGTH);

   state_t           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [4:0]       last_q, last_d;
   logic [31:0]      thr_q, thr_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] smp_q, smp_d;
   logic [CNT_W-1:0] det_q, det_d;
   logic             cfg_err_q, cfg_err_d;

   logic             cfg_bad;
   logic [CNT_W-1:0] smp_inc;

   // A reversed range or an index past the codeword makes the whole campaign
   // invalid; it is rejected up front rather than silently clipped.
   assign cfg_bad = (i_first_idx > i_last_idx) || ({1'b0, i_last_idx} >= CW_LEN);
   assign smp_inc = smp_q + CNT_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         last_q    <= '0;
         thr_q     <= '0;
         num_q     <= '0;
         smp_q     <= '0;
         det_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         thr_q     <= thr_d;
         num_q     <= num_d;
         smp_q     <= smp_d;
         det_q     <= det_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      thr_d     = thr_q;
      num_d     = num_q;
      smp_d     = smp_q;
      det_d     = det_q;
      cfg_err_d = cfg_err_q;

      if (i_clk_en) begin
         if (i_abort) begin
            // Abort wins over every other transition, including a start.
            state_d = ST_IDLE;
            smp_d   = '0;
            det_d   = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (i_start) begin
                     thr_d  = i_threshold;
                     last_d = i_last_idx;
                     num_d  = i_num_samples;
                     idx_d  = i_first_idx;
                     smp_d  = '0;
                     det_d  = '0;
                     if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_DONE;
                     end else begin
                        cfg_err_d = 1'b0;
                        state_d   = ST_SETUP;
                     end
                  end
               end
               ST_SETUP: begin
                  smp_d   = '0;
                  det_d   = '0;
                  // A zero sample budget has nothing to measure.
                  state_d = (num_q == '0) ? ST_REPORT : ST_RUN;
               end
               ST_RUN: begin
                  if (i_dec_valid) begin
                     smp_d = smp_inc;
                     if (i_dec_err) begin
                        det_d = det_q + CNT_W'(1);
                     end
                     // Leave on the very strobe that completes the budget so
                     // that strobe is included in the count.
                     if (smp_inc == num_q) begin
                        state_d = ST_REPORT;
                     end
                  end
               end
               ST_REPORT: begin
                  if (i_result_ready) begin
                     if (idx_q == last_q) begin
                        state_d = ST_DONE;
                     end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_SETUP;
                     end
                  end
               end
               ST_DONE: begin
                  state_d = ST_IDLE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   // The injector only sees the threshold while it is actually being used, so
   // it stays inert between sweep points and outside campaigns.
   assign o_constant     = (state_q == ST_SETUP || state_q == ST_RUN) ? thr_q : 32'd0;
   assign o_random_idx   = idx_q;
   assign o_inj_clk_en   = (state_q == ST_RUN) ? i_clk_en : 1'b0;
   assign o_result_valid = (state_q == ST_REPORT);
   assign o_result_idx   = (state_q == ST_REPORT) ? idx_q : 5'd0;
   assign o_result_count = (state_q == ST_REPORT) ? det_q : '0;
   assign o_busy         = (state_q == ST_SETUP) || (state_q == ST_RUN) || (state_q == ST_REPORT);
   assign o_done         = (state_q == ST_DONE);
   assign o_cfg_err      = cfg_err_q;
   assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_error_campaign_sequencer.sv
// -----------------------------------------------------------------------------
// tb_error_campaign_sequencer
//
// Bench for error_campaign_sequencer. Each campaign is described as per-cycle
// input streams (clock enable, decoder strobe/flag, consumer ready). A
// reference model walks those streams through the sweep rules (one setup
// cycle per index, count strobes up to the budget, wait for acceptance) and
// queues the expected {idx, count} results. A monitor compares every accepted
// result against the queue and checks output invariants each cycle.
// -----------------------------------------------------------------------------
module tb_error_campaign_sequencer;

   localparam int CWL   = 29;
   localparam int CNT_W = 16;
   localparam int W     = 5 + CNT_W;
   localparam int MAXC  = 512;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             i_clk_en;
   logic             i_start;
   logic             i_abort;
   logic [31:0]      i_threshold;
   logic [4:0]       i_first_idx;
   logic [4:0]       i_last_idx;
   logic [CNT_W-1:0] i_num_samples;
   logic             i_dec_valid;
   logic             i_dec_err;
   logic             i_result_ready;
   logic [31:0]      o_constant;
   logic [4:0]       o_random_idx;
   logic             o_inj_clk_en;
   logic             o_result_valid;
   logic [4:0]       o_result_idx;
   logic [CNT_W-1:0] o_result_count;
   logic             o_busy;
   logic             o_done;
   logic             o_cfg_err;
   logic [2:0]       o_dbg_state;

   error_campaign_sequencer #(
      .CODEWORD_LENGTH(CWL),
      .CNT_W          (CNT_W)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_clk_en      (i_clk_en),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_threshold   (i_threshold),
      .i_first_idx   (i_first_idx),
      .i_last_idx    (i_last_idx),
      .i_num_samples (i_num_samples),
      .i_dec_valid   (i_dec_valid),
      .i_dec_err     (i_dec_err),
      .i_result_ready(i_result_ready),
      .o_constant    (o_constant),
      .o_random_idx  (o_random_idx),
      .o_inj_clk_en  (o_inj_clk_en),
      .o_result_valid(o_result_valid),
      .o_result_idx  (o_result_idx),
      .o_result_count(o_result_count),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_cfg_err     (o_cfg_err),
      .o_dbg_state   (o_dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   bit en_a [0:MAXC-1];
   bit v_a  [0:MAXC-1];
   bit e_a  [0:MAXC-1];
   bit r_a  [0:MAXC-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   // Samples 2 time units after each falling edge, i.e. with the inputs for the
   // coming rising edge already applied and well away from that edge.
   bit           hold_v = 1'b0;
   logic [W-1:0] hold_val;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            check("inj_en_only_when_enabled_busy",
                  32'(o_inj_clk_en & ~(i_clk_en & o_busy)), 32'd0);
            if (!o_busy || o_result_valid) begin
               check("constant_zero_outside_setup_run", o_constant, 32'd0);
            end
            if (o_result_valid) begin
               if (hold_v) begin
                  check("result_stable", 32'({o_result_idx, o_result_count}), 32'(hold_val));
               end
               if (i_result_ready && i_clk_en) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_result", 32'({o_result_idx, o_result_count}), 32'hFFFF_FFFF);
                  end else begin
                     check("result", 32'({o_result_idx, o_result_count}), 32'(exp_q.pop_front()));
                  end
                  hold_v = 1'b0;
               end else begin
                  hold_v   = 1'b1;
                  hold_val = {o_result_idx, o_result_count};
               end
            end else begin
               hold_v = 1'b0;
            end
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic drive_idle();
      i_start        = 1'b0;
      i_abort        = 1'b0;
      i_clk_en       = 1'b1;
      i_dec_valid    = 1'b0;
      i_dec_err      = 1'b0;
      i_result_ready = 1'b0;
   endtask

   // mode 0: random streams, 1: everything high, 2: ready low until cycle 14,
   // 3: clock enable low for cycles 4..8.
   task automatic run_campaign(input int first, input int last, input int n,
                               input logic [31:0] thr, input int mode);
      int c;
      int cend;
      for (int k = 0; k < MAXC; k++) begin
         case (mode)
            0: begin
               en_a[k] = ($urandom_range(0, 9) < 8);
               v_a[k]  = ($urandom_range(0, 9) < 7);
               e_a[k]  = ($urandom_range(0, 1) == 1);
               r_a[k]  = ($urandom_range(0, 9) < 6);
            end
            1: begin
               en_a[k] = 1'b1; v_a[k] = 1'b1; e_a[k] = 1'b1; r_a[k] = 1'b1;
            end
            2: begin
               en_a[k] = 1'b1; v_a[k] = 1'b1;
               e_a[k]  = ($urandom_range(0, 1) == 1);
               r_a[k]  = (k >= 14);
            end
            default: begin
               en_a[k] = !(k >= 4 && k < 9); v_a[k] = 1'b1; e_a[k] = 1'b1; r_a[k] = 1'b1;
            end
         endcase
         if (k >= MAXC - 64) begin
            en_a[k] = 1'b1; v_a[k] = 1'b1; r_a[k] = 1'b1;
         end
      end
      en_a[0] = 1'b1;

      // Reference model: walk the streams through the sweep rules.
      c = 1;
      for (int idx = first; idx <= last; idx++) begin
         int cnt;
         int det;
         while (!en_a[c]) c++;
         c++;                                // the one setup cycle
         cnt = 0;
         det = 0;
         while (cnt < n) begin
            if (en_a[c] && v_a[c]) begin
               cnt++;
               if (e_a[c]) det++;
            end
            c++;
         end
         while (!(en_a[c] && r_a[c])) c++;
         c++;                                // acceptance edge
         exp_q.push_back({idx[4:0], det[CNT_W-1:0]});
      end
      cend = c;                              // cycle during which done shows
      en_a[cend] = 1'b1;

      @(negedge clk);
      i_threshold   = thr;
      i_first_idx   = first[4:0];
      i_last_idx    = last[4:0];
      i_num_samples = n[CNT_W-1:0];
      i_abort       = 1'b0;
      for (int k = 0; k <= cend; k++) begin
         if (k > 0) @(negedge clk);
         i_start        = (k == 0);
         i_clk_en       = en_a[k];
         i_dec_valid    = v_a[k];
         i_dec_err      = e_a[k];
         i_result_ready = r_a[k];
         #3;
         if (k == 1) begin
            check("setup_busy", 32'(o_busy), 32'd1);
            check("setup_constant", o_constant, thr);
            check("setup_idx", 32'(o_random_idx), 32'(first));
         end
         if (mode == 3 && k == 3) check("run_inj_en", 32'(o_inj_clk_en), 32'd1);
         if (mode == 3 && k == 6) begin
            check("frozen_busy", 32'(o_busy), 32'd1);
            check("frozen_inj_en", 32'(o_inj_clk_en), 32'd0);
         end
         if (k == cend) begin
            check("done_pulse", 32'(o_done), 32'd1);
            check("done_not_busy", 32'(o_busy), 32'd0);
            check("done_cfg_err", 32'(o_cfg_err), 32'd0);
         end
      end
      @(negedge clk);
      drive_idle();
      #3;
      check("done_one_cycle", 32'(o_done), 32'd0);
      check("results_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic run_bad_cfg(input int first, input int last);
      @(negedge clk);
      drive_idle();
      i_threshold   = $urandom;
      i_first_idx   = first[4:0];
      i_last_idx    = last[4:0];
      i_num_samples = 16'd3;
      i_start       = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      #3;
      check("badcfg_done", 32'(o_done), 32'd1);
      check("badcfg_err", 32'(o_cfg_err), 32'd1);
      check("badcfg_not_busy", 32'(o_busy), 32'd0);
      check("badcfg_no_result", 32'(o_result_valid), 32'd0);
      @(negedge clk);
      #3;
      check("badcfg_done_once", 32'(o_done), 32'd0);
      repeat (3) @(negedge clk);
      #3;
      check("badcfg_err_held", 32'(o_cfg_err), 32'd1);
      check("badcfg_idle", 32'(o_busy), 32'd0);
   endtask

   task automatic run_abort();
      @(negedge clk);
      drive_idle();
      i_threshold   = $urandom | 32'h1;
      i_first_idx   = 5'd3;
      i_last_idx    = 5'd3;
      i_num_samples = 16'd20;
      i_start       = 1'b1;
      i_dec_valid   = 1'b1;
      i_dec_err     = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (4) @(negedge clk);
      i_abort = 1'b1;
      #3;
      check("abort_pre_busy", 32'(o_busy), 32'd1);
      check("abort_pre_idx", 32'(o_random_idx), 32'd3);
      @(negedge clk);
      i_abort = 1'b0;
      #3;
      check("abort_not_busy", 32'(o_busy), 32'd0);
      check("abort_constant", o_constant, 32'd0);
      check("abort_no_result", 32'(o_result_valid), 32'd0);
      check("abort_no_done", 32'(o_done), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #3;
         check("abort_stays_idle", 32'({o_busy, o_done}), 32'd0);
      end
      drive_idle();
   endtask

   task automatic run_reset();
      @(negedge clk);
      drive_idle();
      i_threshold   = $urandom | 32'h1;
      i_first_idx   = 5'd2;
      i_last_idx    = 5'd4;
      i_num_samples = 16'd8;
      i_start       = 1'b1;
      i_dec_valid   = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_constant", o_constant, 32'd0);
      check("rst_idx", 32'(o_random_idx), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_result", 32'({o_result_valid, o_result_idx, o_result_count}), 32'd0);
      check("rst_status", 32'({o_done, o_cfg_err, o_inj_clk_en}), 32'd0);
      exp_q.delete();
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      @(negedge clk);
      #3;
      check("rst_release_idle", 32'(o_busy), 32'd0);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      drive_idle();
      i_threshold   = '0;
      i_first_idx   = '0;
      i_last_idx    = '0;
      i_num_samples = '0;
      rst_n         = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_done", 32'(o_done), 32'd0);
      check("reset_constant", o_constant, 32'd0);
      check("reset_idx", 32'(o_random_idx), 32'd0);
      check("reset_result", 32'(o_result_valid), 32'd0);
      check("reset_cfg_err", 32'(o_cfg_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_campaign(0, 2, 4, $urandom | 32'h1, 1);   // three results of 4 each
      run_bad_cfg(5, 3);                            // reversed range
      run_bad_cfg(0, CWL);                          // last index past codeword
      run_campaign(7, 7, 0, $urandom | 32'h1, 0);   // zero sample budget
      run_campaign(1, 2, 2, $urandom | 32'h1, 2);   // consumer stalls in REPORT
      run_abort();
      run_reset();
      run_campaign(1, 1, 5, $urandom | 32'h1, 3);   // clock enable freeze
      run_campaign(CWL - 1, CWL - 1, 3, $urandom, 0);

      for (int t = 0; t < 12; t++) begin
         int f;
         int l;
         f = $urandom_range(0, CWL - 1);
         l = f + $urandom_range(0, 3);
         if (l > CWL - 1) l = CWL - 1;
         run_campaign(f, l, $urandom_range(0, 8), $urandom, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
